// File: rtl/uat_tx_core.sv
// Asynchronous-serial transmitter: start bit, DATA_W data bits LSB first, optional parity, stop bits.
// Optional parity bit is compiled in when UAT_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | line idle high, tx_ready asserted, waiting for payload
// ST_START  | driving the start bit (low)
// ST_DATA   | shifting payload bits out, LSB first
// ST_PARITY | driving parity of the latched payload (macro only)
// ST_STOP   | driving STOP_BITS stop bits (high)
module uat_tx_core #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UAT_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                baud_tc;
    logic [BAUD_W-1:0]   baud_step;
    logic                ready_c;
    logic                txd_c;
    logic                busy_c;
    logic                done_c;

`ifdef UAT_TX_PARITY_EN
    localparam logic PAR_INIT = 1'(PARITY_ODD);
    logic parity_q, parity_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    // Down-counter: a bit boundary is the cycle the counter reaches zero.
    assign baud_tc   = (baud_q == '0);
    assign baud_step = baud_tc ? BAUD_LOAD : baud_q - BAUD_W'(1);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
`ifdef UAT_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        ready_c    = 1'b0;
        txd_c      = 1'b1;
        busy_c     = 1'b1;
        done_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (tx_valid) begin
                    state_d    = ST_START;
                    baud_d     = BAUD_LOAD;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = tx_data;
`ifdef UAT_TX_PARITY_EN
                    parity_d   = (^tx_data) ^ PAR_INIT;
`endif
                end
            end
            ST_START: begin
                txd_c  = 1'b0;
                baud_d = baud_step;
                if (baud_tc) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_c  = shift_q[0];
                baud_d = baud_step;
                if (baud_tc) begin
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UAT_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UAT_TX_PARITY_EN
            ST_PARITY: begin
                txd_c  = parity_q;
                baud_d = baud_step;
                if (baud_tc) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                baud_d = baud_step;
                if (baud_tc) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
`ifdef UAT_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
`ifdef UAT_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Ready is withheld while reset is asserted so no handshake appears to occur.
    assign tx_ready   = ready_c & rst_n;
    assign txd        = txd_c;
    assign busy       = busy_c;
    assign frame_done = done_c;

endmodule

// File: tb/tb_uat_tx_core.sv
// Bench for uat_tx_core: frame-level model compared every cycle, plus literal frame checks.
// Follows UAT_TX_PARITY_EN in the same way as the design.
module tb_uat_tx_core;

    localparam int DW_A = 8, CPB_A = 4, SB_A = 1, PO_A = 0;
    localparam int DW_B = 5, CPB_B = 2, SB_B = 2;
`ifdef UAT_TX_PARITY_EN
    localparam int P_A = 1;
    localparam logic [15:0] EXP_A5 = 16'h054A;
    localparam logic [15:0] EXP_07 = 16'h060E;
    localparam logic [15:0] EXP_96 = 16'h052C;
    localparam logic [15:0] EXP_B03 = 16'h0186;
`else
    localparam int P_A = 0;
    localparam logic [15:0] EXP_A5 = 16'h034A;
    localparam logic [15:0] EXP_07 = 16'h020E;
    localparam logic [15:0] EXP_96 = 16'h032C;
    localparam logic [15:0] EXP_B03 = 16'h00C6;
`endif
    localparam int FRAME_A = (1 + DW_A + P_A + SB_A) * CPB_A;
    localparam int FRAME_B = (1 + DW_B + P_A + SB_B) * CPB_B;

    logic clk, rst_n;
    logic [7:0] a_data;
    logic a_valid, a_ready, a_txd, a_busy, a_done;
    logic [4:0] b_data;
    logic b_valid, b_ready, b_txd, b_busy, b_done;

    int n_checks = 0;
    int n_fail = 0;

    uat_tx_core #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A), .PARITY_ODD(PO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .txd(a_txd), .busy(a_busy), .frame_done(a_done)
    );

    uat_tx_core #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .txd(b_txd), .busy(b_busy), .frame_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame seen as a sequence of bit slots: start, data LSB first, parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW_A) return d[b-1];
        if (P_A == 1 && b == DW_A + 1) return (^d) ^ 1'(PO_A);
        return 1'b1;
    endfunction

    // Model: position within the current frame, -1 when idle.
    int m_pos = -1;
    logic [7:0] m_data = '0;
    bit cmp_en = 0;
    logic m_in;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = -1;
        end else if (m_pos < 0) begin
            if (a_valid) begin
                m_pos = 0;
                m_data = a_data;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME_A) m_pos = -1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            m_in = (m_pos >= 0);
            chk("m_busy", a_busy, m_in);
            chk("m_ready", a_ready, !m_in && rst_n);
            chk("m_txd", a_txd, m_in ? exp_bit(m_data, m_pos / CPB_A) : 1'b1);
            chk("m_done", a_done, m_pos == FRAME_A - 1);
        end
    end

    task automatic run_frame(input logic [7:0] d, input bit disturb, output logic [15:0] cap,
                             output int len, output int done_at, output int dones);
        a_data = d;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        cap = '0; len = 0; done_at = 0; dones = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!a_busy) break;
            len = c;
            if ((c - 1) % CPB_A == CPB_A / 2) cap[(c - 1) / CPB_A] = a_txd;
            if (a_done) begin dones++; done_at = c; end
            if (disturb && c == 10) begin a_data = ~d; a_valid = 1'b1; end
            if (disturb && c == 13) a_valid = 1'b0;
        end
    endtask

    logic line [0:127];
    logic bsy  [0:127];

    function automatic logic [7:0] decode(input int base);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = line[base + (1 + j) * CPB_A + 3];
        return v;
    endfunction

    initial begin
        logic [15:0] cap;
        int len, done_at, dones, cnt, run;

        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst_txd", a_txd, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_ready_low", a_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", a_ready, 1'b1);
        chk("rel_b_ready", b_ready, 1'b1);
        @(posedge clk); #1;

        run_frame(8'hA5, 0, cap, len, done_at, dones);
        chk("a5_bits", cap, EXP_A5);
        chk("a5_len", len, FRAME_A);
        chk("a5_done_at", done_at, FRAME_A);
        chk("a5_dones", dones, 1);
        @(posedge clk); #1;

        run_frame(8'h07, 0, cap, len, done_at, dones);
        chk("07_bits", cap, EXP_07);
        chk("07_par_slot", cap[9], 1'b1);
        chk("07_len", len, FRAME_A);
        @(posedge clk); #1;

        run_frame(8'h96, 1, cap, len, done_at, dones);
        chk("dist_bits", cap, EXP_96);
        chk("dist_dones", dones, 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_busy || a_done) cnt++;
        end
        chk("dist_no_extra", cnt, 0);
        @(posedge clk); #1;

        a_data = 8'h55;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_data = 8'hAA;
        for (int c = 1; c <= 2 * FRAME_A + 1; c++) begin
            @(negedge clk);
            line[c] = a_txd;
            bsy[c] = a_busy;
            if (c == FRAME_A + 2) a_valid = 1'b0;
        end
        cnt = 0;
        for (int c = 1; c <= 2 * FRAME_A + 1; c++) if (!bsy[c]) cnt++;
        chk("b2b_gap_cycles", cnt, 1);
        chk("b2b_gap_busy", bsy[FRAME_A + 1], 1'b0);
        chk("b2b_gap_high", line[FRAME_A + 1], 1'b1);
        chk("b2b_start1", line[3], 1'b0);
        chk("b2b_start2", line[FRAME_A + 4], 1'b0);
        chk("b2b_data1", decode(0), 8'h55);
        chk("b2b_data2", decode(FRAME_A + 1), 8'hAA);
        @(negedge clk);
        chk("b2b_idle_after", a_busy, 1'b0);
        @(posedge clk); #1;

        a_data = 8'hC3;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("rstmid_bit3", a_txd, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_txd", a_txd, 1'b1);
        chk("rstmid_busy", a_busy, 1'b0);
        chk("rstmid_done", a_done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstmid_ready", a_ready, 1'b1);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (a_done || a_busy) cnt++;
        end
        chk("rstmid_no_resume", cnt, 0);
        @(posedge clk); #1;

        b_data = 5'h03;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        cap = '0; len = 0; done_at = 0; run = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!b_busy) break;
            len = c;
            run = b_txd ? run + 1 : 0;
            if ((c - 1) % CPB_B == 1) cap[(c - 1) / CPB_B] = b_txd;
            if (b_done) done_at = c;
        end
        chk("b_len", len, FRAME_B);
        chk("b_done_at", done_at, FRAME_B);
        chk("b_stop_high", run, 4);
        chk("b_bits", cap, EXP_B03);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
